// File: rtl/break_select_sequencer.sv
// break_select_sequencer
//
// Drives the break-value counter / heuristic selector pair for one
// unsatisfied clause. Each present literal's occurrence bits are fetched
// from the occurrence store and written into the selector with a one-hot
// wren code. The last literal (or a dedicated no-fetch cycle) issues the
// all-ones select code. The selector's choice is then captured and offered
// to the flip stage over a valid/ready handshake.
//
// Ports:
//   clk                   rising-edge clock
//   reset                 asynchronous, active-low reset
//   start_i               request to process a clause (taken when ready_o=1)
//   clause_vars_i         NSAT packed variable indices, literal k at [k*VAR_BITS +: VAR_BITS]
//   clause_valid_i        literal-present mask
//   abort_i               abandon the current clause (ignored in IDLE and OUT)
//   ready_o               high while idle
//   fetch_req_o           occurrence-fetch request
//   fetch_var_o           variable being fetched
//   fetch_ack_i           fetch data is on the selector inputs this cycle
//   wren_o                selector control: 0 idle, 1<<k store literal k, all-ones select
//   break_values_valid_o  latched literal-present mask
//   selected_i            selector choice (registered in the selector)
//   clause_broken_bits_i  broken bits of the chosen literal (registered in the selector)
//   flip_valid_o          result valid
//   flip_ready_i          flip stage accepts
//   flip_var_o            chosen variable
//   flip_index_o          chosen literal index, 0..NSAT-1
//   flip_clause_bits_o    chosen literal's broken-clause bits

module break_select_sequencer #(
  parameter int NSAT                     = 3,
  parameter int NSAT_BITS                = 2,
  parameter int MAX_CLAUSES_PER_VARIABLE = 20,
  parameter int VAR_BITS                 = 12
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic                                start_i,
  input  logic [NSAT*VAR_BITS-1:0]            clause_vars_i,
  input  logic [NSAT-1:0]                     clause_valid_i,
  input  logic                                abort_i,
  output logic                                ready_o,
  output logic                                fetch_req_o,
  output logic [VAR_BITS-1:0]                 fetch_var_o,
  input  logic                                fetch_ack_i,
  output logic [NSAT_BITS-1:0]                wren_o,
  output logic [NSAT-1:0]                     break_values_valid_o,
  input  logic [NSAT_BITS-1:0]                selected_i,
  input  logic [MAX_CLAUSES_PER_VARIABLE-1:0] clause_broken_bits_i,
  output logic                                flip_valid_o,
  input  logic                                flip_ready_i,
  output logic [VAR_BITS-1:0]                 flip_var_o,
  output logic [NSAT_BITS-1:0]                flip_index_o,
  output logic [MAX_CLAUSES_PER_VARIABLE-1:0] flip_clause_bits_o
);

  localparam logic [NSAT_BITS-1:0] LAST_IDX    = NSAT_BITS'(NSAT - 1);
  localparam logic [NSAT_BITS-1:0] SELECT_CODE = '1;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    LAST_NOFETCH,
    CAPTURE,
    OUT
  } state_t;

  state_t                   state;
  state_t                   state_nxt;
  logic [NSAT*VAR_BITS-1:0] vars_q;
  logic [NSAT-1:0]          valid_q;
  logic [NSAT_BITS-1:0]     k_q;
  logic [NSAT_BITS-1:0]     k_nxt;
  logic [NSAT_BITS-1:0]     lowest_idx;
  logic [NSAT_BITS-1:0]     next_idx;
  logic                     next_found;
  logic [NSAT_BITS-1:0]     cap_idx;
  logic                     accept;

  // Lowest present literal of the incoming clause. Defaults to the last
  // index; an all-zero mask is never accepted so the default is harmless.
  always_comb begin
    lowest_idx = LAST_IDX;
    for (int i = NSAT - 1; i >= 0; i--) begin
      if (clause_valid_i[i]) begin
        lowest_idx = NSAT_BITS'(i);
      end
    end
  end

  // Next present literal above k that still gets a one-hot write. The last
  // literal is handled separately because it carries the select code.
  always_comb begin
    next_idx   = LAST_IDX;
    next_found = 1'b0;
    for (int i = NSAT - 2; i >= 0; i--) begin
      if (valid_q[i] && (i > int'(k_q))) begin
        next_idx   = NSAT_BITS'(i);
        next_found = 1'b1;
      end
    end
  end

  // The selector reports literal NSAT-1 as all-ones.
  assign cap_idx = (selected_i == SELECT_CODE) ? LAST_IDX : selected_i;

  // Next-state and combinational control. abort_i overrides everything in
  // the working states, including a coincident fetch_ack_i.
  always_comb begin
    state_nxt   = state;
    k_nxt       = k_q;
    wren_o      = '0;
    fetch_req_o = 1'b0;
    fetch_var_o = '0;
    accept      = 1'b0;
    case (state)
      IDLE: begin
        if (start_i && (|clause_valid_i)) begin
          accept    = 1'b1;
          k_nxt     = lowest_idx;
          state_nxt = FETCH;
        end
      end
      FETCH: begin
        if (abort_i) begin
          state_nxt = IDLE;
        end else begin
          fetch_req_o = 1'b1;
          fetch_var_o = vars_q[int'(k_q)*VAR_BITS +: VAR_BITS];
          if (fetch_ack_i) begin
            if (k_q == LAST_IDX) begin
              wren_o    = SELECT_CODE;
              state_nxt = CAPTURE;
            end else begin
              wren_o = NSAT_BITS'(1) << k_q;
              if (next_found) begin
                k_nxt = next_idx;
              end else if (valid_q[NSAT-1]) begin
                k_nxt = LAST_IDX;
              end else begin
                state_nxt = LAST_NOFETCH;
              end
            end
          end
        end
      end
      LAST_NOFETCH: begin
        if (abort_i) begin
          state_nxt = IDLE;
        end else begin
          wren_o    = SELECT_CODE;
          state_nxt = CAPTURE;
        end
      end
      CAPTURE: begin
        state_nxt = abort_i ? IDLE : OUT;
      end
      OUT: begin
        if (flip_ready_i) begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // State, literal pointer and the clause latched at acceptance.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      k_q     <= '0;
      vars_q  <= '0;
      valid_q <= '0;
    end else begin
      state <= state_nxt;
      k_q   <= k_nxt;
      if (accept) begin
        vars_q  <= clause_vars_i;
        valid_q <= clause_valid_i;
      end
    end
  end

  // Result registers: loaded once in CAPTURE and held through OUT so the
  // flip stage sees stable data until it accepts. Only the valid flag is
  // cleared by the handshake.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      flip_valid_o       <= 1'b0;
      flip_var_o         <= '0;
      flip_index_o       <= '0;
      flip_clause_bits_o <= '0;
    end else if ((state == CAPTURE) && !abort_i) begin
      flip_valid_o       <= 1'b1;
      flip_index_o       <= cap_idx;
      flip_var_o         <= vars_q[int'(cap_idx)*VAR_BITS +: VAR_BITS];
      flip_clause_bits_o <= clause_broken_bits_i;
    end else if ((state == OUT) && flip_ready_i) begin
      flip_valid_o <= 1'b0;
    end
  end

  assign ready_o              = (state == IDLE);
  assign break_values_valid_o = valid_q;

endmodule

// File: tb/tb_break_select_sequencer.sv
// tb_break_select_sequencer
//
// Self-checking bench for break_select_sequencer. A reference model builds
// the expected per-cycle trace of every DUT output for a clause from the
// literal mask, fetch delays, selector choice and handshake timing; a
// driver runs the clause against the DUT, acting as occurrence store and
// flip stage, and records the observed trace. Each scenario task compares
// the two traces and adds a few directed checks.

module tb_break_select_sequencer;

  localparam int NSAT      = 3;
  localparam int NSAT_BITS = 2;
  localparam int MC        = 20;
  localparam int VB        = 12;
  localparam int CVW       = NSAT * VB;

  logic                 clk = 1'b0;
  logic                 reset;
  logic                 start_i;
  logic [CVW-1:0]       clause_vars_i;
  logic [NSAT-1:0]      clause_valid_i;
  logic                 abort_i;
  logic                 ready_o;
  logic                 fetch_req_o;
  logic [VB-1:0]        fetch_var_o;
  logic                 fetch_ack_i;
  logic [NSAT_BITS-1:0] wren_o;
  logic [NSAT-1:0]      break_values_valid_o;
  logic [NSAT_BITS-1:0] selected_i;
  logic [MC-1:0]        clause_broken_bits_i;
  logic                 flip_valid_o;
  logic                 flip_ready_i;
  logic [VB-1:0]        flip_var_o;
  logic [NSAT_BITS-1:0] flip_index_o;
  logic [MC-1:0]        flip_clause_bits_o;

  break_select_sequencer #(
    .NSAT(NSAT),
    .NSAT_BITS(NSAT_BITS),
    .MAX_CLAUSES_PER_VARIABLE(MC),
    .VAR_BITS(VB)
  ) dut (
    .clk(clk),
    .reset(reset),
    .start_i(start_i),
    .clause_vars_i(clause_vars_i),
    .clause_valid_i(clause_valid_i),
    .abort_i(abort_i),
    .ready_o(ready_o),
    .fetch_req_o(fetch_req_o),
    .fetch_var_o(fetch_var_o),
    .fetch_ack_i(fetch_ack_i),
    .wren_o(wren_o),
    .break_values_valid_o(break_values_valid_o),
    .selected_i(selected_i),
    .clause_broken_bits_i(clause_broken_bits_i),
    .flip_valid_o(flip_valid_o),
    .flip_ready_i(flip_ready_i),
    .flip_var_o(flip_var_o),
    .flip_index_o(flip_index_o),
    .flip_clause_bits_o(flip_clause_bits_o)
  );

  always #5 clk = ~clk;

  // One cycle's worth of DUT outputs.
  typedef struct packed {
    logic                 req;
    logic [VB-1:0]        fvar;
    logic [NSAT_BITS-1:0] wren;
    logic                 ready;
    logic                 fvalid;
    logic [NSAT_BITS-1:0] fidx;
    logic [VB-1:0]        flvar;
    logic [MC-1:0]        fbits;
    logic [NSAT-1:0]      bvv;
  } cyc_t;

  cyc_t obs[$];
  cyc_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  // Scenario parameters shared by the model and the driver.
  logic [VB-1:0]        drv_vars[NSAT];
  logic [NSAT-1:0]      drv_mask;
  int                   drv_delay[NSAT];
  logic [NSAT_BITS-1:0] drv_sel;
  logic [MC-1:0]        drv_broken;
  int                   drv_abort;
  int                   drv_ready_wait;
  bit                   drv_start_in_out;

  // Model view of the registers that persist between clauses.
  logic [NSAT_BITS-1:0] m_fidx;
  logic [VB-1:0]        m_fvar;
  logic [MC-1:0]        m_fbits;
  logic [NSAT-1:0]      m_bvv;

  function automatic cyc_t sample();
    cyc_t s;
    s.req    = fetch_req_o;
    s.fvar   = fetch_var_o;
    s.wren   = wren_o;
    s.ready  = ready_o;
    s.fvalid = flip_valid_o;
    s.fidx   = flip_index_o;
    s.flvar  = flip_var_o;
    s.fbits  = flip_clause_bits_o;
    s.bvv    = break_values_valid_o;
    return s;
  endfunction

  function automatic void model_clear();
    m_fidx  = '0;
    m_fvar  = '0;
    m_fbits = '0;
    m_bvv   = '0;
  endfunction

  function automatic void set_defaults();
    for (int i = 0; i < NSAT; i++) begin
      drv_vars[i]  = VB'($urandom);
      drv_delay[i] = 0;
    end
    drv_mask         = '1;
    drv_sel          = '0;
    drv_broken       = MC'($urandom);
    drv_abort        = -1;
    drv_ready_wait   = 0;
    drv_start_in_out = 1'b0;
  endfunction

  // Expected trace: cycle 0 is the accept cycle, then present literals in
  // ascending order each take (delay) wait cycles plus an ack cycle, an
  // extra select cycle if the last literal is absent, one capture cycle and
  // the OUT cycles up to and including the handshake.
  function automatic void build_expected();
    cyc_t e;
    int   order[$];
    int   sel_idx;
    e        = '0;
    e.ready  = 1'b1;
    e.fidx   = m_fidx;
    e.flvar  = m_fvar;
    e.fbits  = m_fbits;
    e.bvv    = m_bvv;
    exp_q.delete();
    exp_q.push_back(e);
    e.ready = 1'b0;
    e.bvv   = drv_mask;
    m_bvv   = drv_mask;
    for (int i = 0; i < NSAT; i++) begin
      if (drv_mask[i]) order.push_back(i);
    end
    foreach (order[n]) begin
      e.req  = 1'b1;
      e.fvar = drv_vars[order[n]];
      e.wren = '0;
      for (int w = 0; w < drv_delay[n]; w++) exp_q.push_back(e);
      e.wren = (order[n] == NSAT - 1) ? '1 : NSAT_BITS'(1 << order[n]);
      exp_q.push_back(e);
    end
    e.req  = 1'b0;
    e.fvar = '0;
    if (!drv_mask[NSAT-1]) begin
      e.wren = '1;
      exp_q.push_back(e);
    end
    e.wren = '0;
    exp_q.push_back(e);
    if (drv_abort >= 1 && drv_abort < exp_q.size()) begin
      while (exp_q.size() > drv_abort + 1) void'(exp_q.pop_back());
      e      = exp_q[drv_abort];
      e.req  = 1'b0;
      e.fvar = '0;
      e.wren = '0;
      exp_q[drv_abort] = e;
      return;
    end
    sel_idx  = (drv_sel == '1) ? NSAT - 1 : int'(drv_sel);
    m_fidx   = NSAT_BITS'(sel_idx);
    m_fvar   = drv_vars[sel_idx];
    m_fbits  = drv_broken;
    e.fvalid = 1'b1;
    e.fidx   = m_fidx;
    e.flvar  = m_fvar;
    e.fbits  = m_fbits;
    for (int w = 0; w <= drv_ready_wait; w++) exp_q.push_back(e);
  endfunction

  // Plays occurrence store and flip stage for one clause and records the
  // observed outputs mid-cycle. Ends on the handshake or abort cycle.
  task automatic run_clause();
    int fetch_n;
    int wait_n;
    int out_n;
    bit done;
    obs.delete();
    @(posedge clk); #1;
    fetch_ack_i  = 1'b0;
    abort_i      = 1'b0;
    flip_ready_i = 1'b0;
    for (int i = 0; i < NSAT; i++) clause_vars_i[i*VB +: VB] = drv_vars[i];
    clause_valid_i       = drv_mask;
    start_i              = 1'b1;
    selected_i           = drv_sel;
    clause_broken_bits_i = drv_broken;
    @(negedge clk);
    obs.push_back(sample());
    fetch_n = 0;
    wait_n  = 0;
    out_n   = 0;
    done    = 1'b0;
    for (int c = 1; c < 80 && !done; c++) begin
      @(posedge clk); #1;
      start_i        = 1'b0;
      fetch_ack_i    = 1'b0;
      abort_i        = 1'b0;
      flip_ready_i   = 1'b0;
      clause_vars_i  = CVW'({$urandom, $urandom});
      clause_valid_i = NSAT'($urandom);
      #1;
      if (fetch_req_o) begin
        if (fetch_n >= NSAT || wait_n >= drv_delay[fetch_n]) begin
          fetch_ack_i = 1'b1;
          fetch_n++;
          wait_n = 0;
        end else begin
          wait_n++;
        end
      end
      if (c == drv_abort) abort_i = 1'b1;
      if (flip_valid_o) begin
        if (out_n == 1 && drv_start_in_out) start_i = 1'b1;
        if (out_n >= drv_ready_wait) flip_ready_i = 1'b1;
        out_n++;
      end
      @(negedge clk);
      obs.push_back(sample());
      if (abort_i || (flip_valid_o && flip_ready_i)) done = 1'b1;
    end
  endtask

  task automatic test_reset();
    reset                = 1'b0;
    start_i              = 1'b0;
    clause_vars_i        = '0;
    clause_valid_i       = '0;
    abort_i              = 1'b0;
    fetch_ack_i          = 1'b0;
    selected_i           = '0;
    clause_broken_bits_i = '0;
    flip_ready_i         = 1'b0;
    model_clear();
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++; if (ready_o !== 1'b1) begin errors++; $display("[TB] FAIL reset_ready: got %b expected 1", ready_o); end
    checks++; if (fetch_req_o !== 1'b0) begin errors++; $display("[TB] FAIL reset_fetch_req: got %b expected 0", fetch_req_o); end
    checks++; if (fetch_var_o !== '0) begin errors++; $display("[TB] FAIL reset_fetch_var: got %h expected 0", fetch_var_o); end
    checks++; if (wren_o !== '0) begin errors++; $display("[TB] FAIL reset_wren: got %b expected 0", wren_o); end
    checks++; if (break_values_valid_o !== '0) begin errors++; $display("[TB] FAIL reset_bvv: got %b expected 0", break_values_valid_o); end
    checks++; if (flip_valid_o !== 1'b0) begin errors++; $display("[TB] FAIL reset_flip_valid: got %b expected 0", flip_valid_o); end
    checks++; if (flip_var_o !== '0) begin errors++; $display("[TB] FAIL reset_flip_var: got %h expected 0", flip_var_o); end
    checks++; if (flip_index_o !== '0) begin errors++; $display("[TB] FAIL reset_flip_index: got %b expected 0", flip_index_o); end
    checks++; if (flip_clause_bits_o !== '0) begin errors++; $display("[TB] FAIL reset_flip_bits: got %h expected 0", flip_clause_bits_o); end
    reset = 1'b1;
  endtask

  task automatic test_ignore_empty();
    @(posedge clk); #1;
    start_i        = 1'b1;
    clause_valid_i = '0;
    @(posedge clk); #1;
    start_i = 1'b0;
    @(negedge clk);
    checks++; if (ready_o !== 1'b1) begin errors++; $display("[TB] FAIL empty_ready: got %b expected 1", ready_o); end
    checks++; if (fetch_req_o !== 1'b0) begin errors++; $display("[TB] FAIL empty_fetch_req: got %b expected 0", fetch_req_o); end
  endtask

  task automatic test_all_valid();
    set_defaults();
    drv_vars[0] = 12'd5;
    drv_vars[1] = 12'd9;
    drv_vars[2] = 12'd12;
    drv_sel     = 2'b01;
    build_expected();
    run_clause();
    checks++;
    if (obs.size() !== exp_q.size()) begin errors++; $display("[TB] FAIL all_valid_length: got %0d cycles expected %0d", obs.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < obs.size(); i++) begin
      checks++;
      if (obs[i] !== exp_q[i]) begin errors++; $display("[TB] FAIL all_valid_trace cycle %0d: got %h expected %h", i, obs[i], exp_q[i]); end
    end
    checks++;
    if (obs.size() < 6) begin
      errors++; $display("[TB] FAIL all_valid_cycle5: got %0d cycles expected at least 6", obs.size());
    end else if (obs[1].wren !== 2'b01 || obs[2].wren !== 2'b10 || obs[3].wren !== 2'b11 ||
                 obs[5].fvalid !== 1'b1 || obs[5].flvar !== 12'd9 || obs[5].fidx !== 2'd1 ||
                 obs[5].fbits !== drv_broken) begin
      errors++;
      $display("[TB] FAIL all_valid_cycle5: got wren %b/%b/%b fv=%b var=%0d idx=%0d bits=%h expected 01/10/11 fv=1 var=9 idx=1 bits=%h",
               obs[1].wren, obs[2].wren, obs[3].wren, obs[5].fvalid, obs[5].flvar, obs[5].fidx, obs[5].fbits, drv_broken);
    end
  endtask

  task automatic test_delayed_acks();
    set_defaults();
    drv_vars[0] = 12'd5;
    drv_vars[1] = 12'd9;
    drv_vars[2] = 12'd12;
    for (int i = 0; i < NSAT; i++) drv_delay[i] = 2;
    drv_sel = 2'b11;
    build_expected();
    run_clause();
    checks++;
    if (obs.size() !== exp_q.size()) begin errors++; $display("[TB] FAIL delayed_length: got %0d cycles expected %0d", obs.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < obs.size(); i++) begin
      checks++;
      if (obs[i] !== exp_q[i]) begin errors++; $display("[TB] FAIL delayed_trace cycle %0d: got %h expected %h", i, obs[i], exp_q[i]); end
    end
    checks++;
    if (obs.size() < 12) begin
      errors++; $display("[TB] FAIL delayed_cycle11: got %0d cycles expected at least 12", obs.size());
    end else if (obs[10].fvalid !== 1'b0 || obs[11].fvalid !== 1'b1 || obs[11].flvar !== 12'd12 || obs[11].fidx !== 2'd2) begin
      errors++;
      $display("[TB] FAIL delayed_cycle11: got fv10=%b fv11=%b var=%0d idx=%0d expected fv10=0 fv11=1 var=12 idx=2",
               obs[10].fvalid, obs[11].fvalid, obs[11].flvar, obs[11].fidx);
    end
  endtask

  task automatic test_sparse_valid();
    int req_cycles;
    set_defaults();
    drv_vars[0] = 12'd5;
    drv_vars[1] = 12'd9;
    drv_vars[2] = 12'd12;
    drv_mask    = 3'b101;
    drv_sel     = 2'b00;
    build_expected();
    run_clause();
    checks++;
    if (obs.size() !== exp_q.size()) begin errors++; $display("[TB] FAIL sparse_length: got %0d cycles expected %0d", obs.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < obs.size(); i++) begin
      checks++;
      if (obs[i] !== exp_q[i]) begin errors++; $display("[TB] FAIL sparse_trace cycle %0d: got %h expected %h", i, obs[i], exp_q[i]); end
    end
    req_cycles = 0;
    foreach (obs[i]) if (obs[i].req === 1'b1) req_cycles++;
    checks++;
    if (req_cycles !== 2 || obs.size() < 2 || obs[1].bvv !== 3'b101) begin
      errors++;
      $display("[TB] FAIL sparse_fetches: got %0d fetch cycles expected 2 with bvv 101", req_cycles);
    end
  endtask

  task automatic test_last_nofetch();
    set_defaults();
    drv_mask = 3'b011;
    drv_sel  = 2'b01;
    build_expected();
    run_clause();
    checks++;
    if (obs.size() !== exp_q.size()) begin errors++; $display("[TB] FAIL nofetch_length: got %0d cycles expected %0d", obs.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < obs.size(); i++) begin
      checks++;
      if (obs[i] !== exp_q[i]) begin errors++; $display("[TB] FAIL nofetch_trace cycle %0d: got %h expected %h", i, obs[i], exp_q[i]); end
    end
  endtask

  task automatic test_out_hold();
    set_defaults();
    drv_sel          = 2'b10;
    drv_ready_wait   = 3;
    drv_start_in_out = 1'b1;
    build_expected();
    run_clause();
    checks++;
    if (obs.size() !== exp_q.size()) begin errors++; $display("[TB] FAIL out_hold_length: got %0d cycles expected %0d", obs.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < obs.size(); i++) begin
      checks++;
      if (obs[i] !== exp_q[i]) begin errors++; $display("[TB] FAIL out_hold_trace cycle %0d: got %h expected %h", i, obs[i], exp_q[i]); end
    end
    @(posedge clk); #1;
    flip_ready_i = 1'b0;
    @(negedge clk);
    checks++;
    if (ready_o !== 1'b1 || fetch_req_o !== 1'b0 || flip_valid_o !== 1'b0) begin
      errors++;
      $display("[TB] FAIL out_hold_after: got ready=%b req=%b fv=%b expected ready=1 req=0 fv=0", ready_o, fetch_req_o, flip_valid_o);
    end
  endtask

  task automatic test_abort();
    set_defaults();
    drv_abort = 2;
    build_expected();
    run_clause();
    checks++;
    if (obs.size() !== exp_q.size()) begin errors++; $display("[TB] FAIL abort_length: got %0d cycles expected %0d", obs.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < obs.size(); i++) begin
      checks++;
      if (obs[i] !== exp_q[i]) begin errors++; $display("[TB] FAIL abort_trace cycle %0d: got %h expected %h", i, obs[i], exp_q[i]); end
    end
    set_defaults();
    drv_sel = 2'b00;
    build_expected();
    run_clause();
    checks++;
    if (obs.size() !== exp_q.size()) begin errors++; $display("[TB] FAIL after_abort_length: got %0d cycles expected %0d", obs.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < obs.size(); i++) begin
      checks++;
      if (obs[i] !== exp_q[i]) begin errors++; $display("[TB] FAIL after_abort_trace cycle %0d: got %h expected %h", i, obs[i], exp_q[i]); end
    end
  endtask

  task automatic test_back_to_back();
    for (int n = 0; n < 3; n++) begin
      set_defaults();
      drv_sel = NSAT_BITS'($urandom_range(0, 3));
      build_expected();
      run_clause();
      checks++;
      if (obs.size() !== exp_q.size()) begin errors++; $display("[TB] FAIL b2b_length run %0d: got %0d cycles expected %0d", n, obs.size(), exp_q.size()); end
      for (int i = 0; i < exp_q.size() && i < obs.size(); i++) begin
        checks++;
        if (obs[i] !== exp_q[i]) begin errors++; $display("[TB] FAIL b2b_trace run %0d cycle %0d: got %h expected %h", n, i, obs[i], exp_q[i]); end
      end
    end
  endtask

  task automatic test_reset_mid_fetch();
    set_defaults();
    drv_sel = 2'b01;
    @(posedge clk); #1;
    for (int i = 0; i < NSAT; i++) clause_vars_i[i*VB +: VB] = drv_vars[i];
    clause_valid_i = '1;
    start_i        = 1'b1;
    @(posedge clk); #1;
    start_i = 1'b0;
    @(posedge clk); #1;
    fetch_ack_i = 1'b1;
    #1;
    reset = 1'b0;
    #1;
    checks++;
    if (ready_o !== 1'b1 || fetch_req_o !== 1'b0 || fetch_var_o !== '0 || wren_o !== '0 ||
        break_values_valid_o !== '0 || flip_valid_o !== 1'b0 || flip_var_o !== '0 ||
        flip_index_o !== '0 || flip_clause_bits_o !== '0) begin
      errors++;
      $display("[TB] FAIL mid_reset_outputs: got ready=%b req=%b var=%h wren=%b bvv=%b fv=%b fvar=%h idx=%b bits=%h expected ready=1 and all others 0",
               ready_o, fetch_req_o, fetch_var_o, wren_o, break_values_valid_o, flip_valid_o, flip_var_o, flip_index_o, flip_clause_bits_o);
    end
    model_clear();
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    checks++;
    if (ready_o !== 1'b1 || fetch_req_o !== 1'b0 || wren_o !== '0) begin
      errors++;
      $display("[TB] FAIL mid_reset_stale_ack: got ready=%b req=%b wren=%b expected ready=1 req=0 wren=00", ready_o, fetch_req_o, wren_o);
    end
    fetch_ack_i = 1'b0;
  endtask

  task automatic test_random();
    int order_n;
    int span;
    int picks[$];
    for (int n = 0; n < 40; n++) begin
      set_defaults();
      drv_mask = NSAT'($urandom_range(1, (1 << NSAT) - 1));
      for (int i = 0; i < NSAT; i++) drv_delay[i] = int'($urandom_range(0, 2));
      picks.delete();
      for (int i = 0; i < NSAT; i++) if (drv_mask[i]) picks.push_back(i);
      drv_sel = NSAT_BITS'(picks[$urandom_range(0, picks.size() - 1)]);
      if (drv_sel == NSAT_BITS'(NSAT - 1) && $urandom_range(0, 1) == 1) drv_sel = '1;
      drv_ready_wait   = int'($urandom_range(0, 3));
      drv_start_in_out = 1'($urandom_range(0, 1));
      span    = 1;
      order_n = 0;
      for (int i = 0; i < NSAT; i++) begin
        if (drv_mask[i]) begin
          span += drv_delay[order_n] + 1;
          order_n++;
        end
      end
      if (!drv_mask[NSAT-1]) span++;
      if ($urandom_range(0, 3) == 0) drv_abort = int'($urandom_range(1, span));
      build_expected();
      run_clause();
      checks++;
      if (obs.size() !== exp_q.size()) begin errors++; $display("[TB] FAIL random_length run %0d: got %0d cycles expected %0d", n, obs.size(), exp_q.size()); end
      for (int i = 0; i < exp_q.size() && i < obs.size(); i++) begin
        checks++;
        if (obs[i] !== exp_q[i]) begin errors++; $display("[TB] FAIL random_trace run %0d cycle %0d: got %h expected %h", n, i, obs[i], exp_q[i]); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_ignore_empty();
    test_all_valid();
    test_delayed_acks();
    test_sparse_valid();
    test_last_nofetch();
    test_out_hold();
    test_abort();
    test_back_to_back();
    test_reset_mid_fetch();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/break_select_sequencer.md
# break_select_sequencer

Control-side driver of the break-value counter/heuristic selector pair. For one selected unsatisfied clause it fetches each candidate literal's clause-occurrence bits from the occurrence store and drives the `wren` code (one-hot writes, then all-ones select). It then captures the selector's choice and hands the variable to flip, plus its broken-clause bits, to the flip stage over a valid/ready handshake.

## Interface
- NSAT, 3, literals per clause; NSAT >= 3.
- NSAT_BITS, 2, width of the wren/select code; must equal NSAT-1.
- MAX_CLAUSES_PER_VARIABLE, 20, width of broken-bit vectors (MC).
- VAR_BITS, 12, width of a variable index.
- clk  in  1  single clock; everything is on its rising edge.
- reset  in  1  reset is asynchronous and active-low.
- start_i  in  1  request to process a clause; accepted when ready_o=1.
- clause_vars_i  in  NSAT*VAR_BITS  literal variable indices; literal k is at [k*VAR_BITS +: VAR_BITS].
- clause_valid_i  in  NSAT  literal-present mask.
- abort_i  in  1  synchronous abandon of the current clause.
- ready_o  out  1  high in IDLE.
- fetch_req_o  out  1  occurrence-fetch request.
- fetch_var_o  out  VAR_BITS  variable being fetched.
- fetch_ack_i  in  1  fetch data is valid on the selector's clause_broken/mask inputs this cycle.
- wren_o  out  NSAT_BITS  selector control: 0 = idle, 1<<k = store literal k, all-ones = select.
- break_values_valid_o  out  NSAT  latched clause_valid_i.
- selected_i  in  NSAT_BITS  selector choice, registered inside the selector.
- clause_broken_bits_i  in  MC  broken bits of the chosen literal, registered inside the selector.
- flip_valid_o  out  1  result valid.
- flip_ready_i  in  1  flip stage accepts.
- flip_var_o  out  VAR_BITS  chosen variable.
- flip_index_o  out  NSAT_BITS  chosen literal index, 0..NSAT-1.
- flip_clause_bits_o  out  MC  chosen literal's broken-clause bits.

## Operation
- States: IDLE, FETCH, LAST_NOFETCH, CAPTURE, OUT.
- IDLE:
  - On start_i with clause_valid_i != 0, latch clause_vars_i and clause_valid_i, then set k = lowest valid index.
  - If the lowest valid index is NSAT-1, go to FETCH. If literal NSAT-1 is the only literal and is invalid, this case does not arise.
  - start_i with clause_valid_i == 0 is ignored and ready_o stays 1.
- FETCH:
  - fetch_req_o=1 and fetch_var_o=vars[k], both held stable until fetch_ack_i.
  - On the ack cycle, wren_o is driven combinationally: 1<<k if k<NSAT-1, all-ones if k==NSAT-1.
  - After the ack, k advances to the next valid index below NSAT-1.
  - If none remains: go to FETCH with k=NSAT-1 if literal NSAT-1 is valid, otherwise go to LAST_NOFETCH.
  - After the k==NSAT-1 ack, go to CAPTURE.
- LAST_NOFETCH: one cycle with wren_o=all-ones and fetch_req_o=0, then go to CAPTURE.
- Invalid literals are never fetched and get no one-hot write. Their stale selector registers are masked by break_values_valid_o.
- CAPTURE:
  - Register flip_index_o = (selected_i == all-ones) ? NSAT-1 : selected_i.
  - Register flip_var_o = vars[that index] and flip_clause_bits_o = clause_broken_bits_i.
  - Set flip_valid_o and go to OUT.
- OUT:
  - Outputs are held stable while flip_valid_o=1 and flip_ready_i=0.
  - On flip_ready_i, clear flip_valid_o and go to IDLE; ready_o rises the next cycle.
  - start_i is ignored outside IDLE.
- abort_i:
  - In FETCH, LAST_NOFETCH or CAPTURE: go to IDLE next cycle, with wren_o=0 and fetch_req_o=0 in the abort cycle.
  - In OUT: ignored; the handshake completes.
  - abort_i has priority over fetch_ack_i in the same cycle.
- wren_o is 0 in every cycle not listed above.

## Timing
- Reset values:
  - ready_o=1.
  - All other outputs 0.
  - State IDLE, latched vars and mask 0.
- Reset asserted mid-operation clears everything asynchronously. An in-flight fetch_ack_i after reset is ignored.
- fetch_ack_i may arrive in the first fetch_req_o cycle (zero wait).
- Minimum latency with all literals valid and zero-wait acks:
  - cycle 0: start accepted.
  - cycles 1..NSAT: FETCH.
  - cycle NSAT+1: CAPTURE.
  - cycle NSAT+2: flip_valid_o=1. For NSAT=3 that is cycle 5.
- Each fetch wait cycle adds exactly one cycle of latency.
- Back-to-back throughput: the next start is accepted in the cycle after the flip handshake.

## Test plan
- All valid, vars 5/9/12, zero-wait acks, selected_i=01 -> wren_o 01,10,11 on cycles 1,2,3; flip_valid_o at cycle 5 with flip_var_o=9, flip_index_o=1, flip_clause_bits_o = value driven on clause_broken_bits_i.
- Acks delayed 2 cycles each, selected_i=11 -> fetch_var_o stable during each wait, flip_var_o=12, flip_index_o=2, flip_valid_o at cycle 11.
- clause_valid_i=101 -> fetches only for vars 5 and 12, wren_o sequence 01 then 11, break_values_valid_o=101.
- clause_valid_i=011 -> wren_o 01, 10, then a LAST_NOFETCH cycle with 11 and fetch_req_o=0.
- flip_ready_i low for 3 cycles with a start_i pulse during OUT -> outputs unchanged, start ignored, ready_o=1 one cycle after the accept.
- abort_i coinciding with the second ack -> wren_o=0 that cycle and IDLE next; reset asserted mid-FETCH -> all outputs at reset values immediately, ready_o=1.
